// File: rtl/mem_access_if.sv
// Bundle of the pipeline-side, data-bus-side and status signals of mem_access_unit.
// AlignErr exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_access_if;
  logic        MemRead;
  logic        MemWrite;
  logic [3:0]  MEMop;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [3:0]  MemBe;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        Stall;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        BusErr;
`ifdef MEM_ALIGN_CHECK_EN
  logic        AlignErr;
`endif

  // master: the access unit itself; slave: pipeline + memory environment
  modport master (
`ifdef MEM_ALIGN_CHECK_EN
    output AlignErr,
`endif
    input  MemRead, MemWrite, MEMop, Addr, StoreData, MemAck, MemRData,
    output MemReq, MemWe, MemAddr, MemBe, MemWData, Stall, LoadData, LoadValid, BusErr
  );

  modport slave (
`ifdef MEM_ALIGN_CHECK_EN
    input  AlignErr,
`endif
    output MemRead, MemWrite, MEMop, Addr, StoreData, MemAck, MemRData,
    input  MemReq, MemWe, MemAddr, MemBe, MemWData, Stall, LoadData, LoadValid, BusErr
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: req/ack bus transaction, pipeline stall, load formatting.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
//
// state  | meaning
// S_IDLE | waiting for MemRead/MemWrite; latches the access when one appears
// S_REQ  | MemReq held, waiting for MemAck or timeout
// S_DONE | pipeline released; LoadValid/BusErr/AlignErr pulse here
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input logic          Clk,
  input logic          Rst_n,
  mem_access_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  size_t             size_q, size_d;
  logic              sext_q, sext_d;
  logic              is_load_q, is_load_d;
  logic [1:0]        lane_q, lane_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              bus_err_q, bus_err_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic              align_err_q, align_err_d;
  logic              misaligned;
`endif

  logic              access;
  logic              req_store;
  size_t             dec_size;
  logic              dec_sext;
  logic [3:0]        dec_be;
  logic [31:0]       dec_wdata;

  function automatic logic [31:0] fmt_load(input logic [31:0] rd, input size_t sz,
                                           input logic sx, input logic [1:0] lane);
    logic [15:0] h;
    logic [7:0]  b;
    h = lane[1] ? rd[31:16] : rd[15:0];
    b = rd[{lane, 3'b000} +: 8];
    case (sz)
      SZ_HALF: fmt_load = {{16{sx & h[15]}}, h};
      SZ_BYTE: fmt_load = {{24{sx & b[7]}}, b};
      default: fmt_load = rd;
    endcase
  endfunction

  // Store wins when both strobes are set
  always_comb begin
    access    = bus.MemRead | bus.MemWrite;
    req_store = bus.MemWrite;
    dec_size  = SZ_WORD;
    dec_sext  = 1'b0;
    if (req_store) begin
      case (bus.MEMop)
        4'b1001: dec_size = SZ_HALF;
        4'b1010: dec_size = SZ_BYTE;
        default: dec_size = SZ_WORD;
      endcase
    end else begin
      case (bus.MEMop)
        4'b0001: begin dec_size = SZ_HALF; dec_sext = 1'b1; end
        4'b0010: dec_size = SZ_HALF;
        4'b0011: begin dec_size = SZ_BYTE; dec_sext = 1'b1; end
        4'b0100: dec_size = SZ_BYTE;
        default: dec_size = SZ_WORD;
      endcase
    end

    case (dec_size)
      SZ_HALF: begin
        dec_be    = bus.Addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{bus.StoreData[15:0]}};
      end
      SZ_BYTE: begin
        dec_be    = 4'b0001 << bus.Addr[1:0];
        dec_wdata = {4{bus.StoreData[7:0]}};
      end
      default: begin
        dec_be    = 4'b1111;
        dec_wdata = bus.StoreData;
      end
    endcase
    if (!req_store) begin
      dec_be    = 4'b1111;
      dec_wdata = 32'h0;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((dec_size == SZ_WORD) && (bus.Addr[1:0] != 2'b00)) ||
                      ((dec_size == SZ_HALF) && bus.Addr[0]);
`endif

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    size_d       = size_q;
    sext_d       = sext_q;
    is_load_d    = is_load_q;
    lane_d       = lane_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    align_err_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (access) begin
          size_d      = dec_size;
          sext_d      = dec_sext;
          is_load_d   = ~req_store;
          lane_d      = bus.Addr[1:0];
          mem_we_d    = req_store;
          mem_addr_d  = {bus.Addr[31:2], 2'b00};
          mem_be_d    = dec_be;
          mem_wdata_d = dec_wdata;
          mem_req_d   = 1'b1;
          state_d     = S_REQ;
`ifdef MEM_ALIGN_CHECK_EN
          if (misaligned) begin
            mem_req_d   = 1'b0;
            align_err_d = 1'b1;
            state_d     = S_DONE;
            if (!req_store) load_data_d = 32'h0;
          end
`endif
        end
      end
      S_REQ: begin
        if (bus.MemAck) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          if (is_load_q) begin
            load_data_d  = fmt_load(bus.MemRData, size_q, sext_q, lane_q);
            load_valid_d = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
          // Abort once the TIMEOUT_CYCLES-th REQ cycle has passed with no ack
          if ((TIMEOUT_CYCLES != 0) && (count_d == TO_LIM)) begin
            mem_req_d = 1'b0;
            bus_err_d = 1'b1;
            state_d   = S_DONE;
            if (is_load_q) load_data_d = 32'h0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      size_q       <= SZ_WORD;
      sext_q       <= 1'b0;
      is_load_q    <= 1'b0;
      lane_q       <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'h0;
      mem_wdata_q  <= 32'h0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      is_load_q    <= is_load_d;
      lane_q       <= lane_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q  <= align_err_d;
`endif
    end
  end

  // Stall must release in DONE so the pipeline advances on that edge
  assign bus.Stall     = ((state_q == S_IDLE) && access) || (state_q == S_REQ);
  assign bus.MemReq    = mem_req_q;
  assign bus.MemWe     = mem_we_q;
  assign bus.MemAddr   = mem_addr_q;
  assign bus.MemBe     = mem_be_q;
  assign bus.MemWData  = mem_wdata_q;
  assign bus.LoadData  = load_data_q;
  assign bus.LoadValid = load_valid_q;
  assign bus.BusErr    = bus_err_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign bus.AlignErr  = align_err_q;
`endif

endmodule
